// File: rtl/btn_cmd_sched.sv
// Button command scheduler: per-button press/long/repeat event detection with a
// one-slot pending queue per button, serialised by a round-robin valid/ready arbiter.

module btn_lane #(
  parameter int              CW         = 24,
  parameter logic [CW-1:0]   LONG_CYC   = 24'd5000000,
  parameter logic [CW-1:0]   REPEAT_CYC = 24'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic pend,
  output logic kind,
  output logic drop
);
  localparam logic [CW-1:0] LAST   = CW'(LONG_CYC - 1'b1);
  localparam logic [CW-1:0] RELOAD = CW'(LONG_CYC - REPEAT_CYC);

  logic          prev_btn;
  logic [CW-1:0] cnt, cnt_inc;
  logic          rise, held, long_ev, ev;

  assign rise    = btn & ~prev_btn;
  assign held    = btn & prev_btn;
  // Counter sits at LAST for exactly one cycle, then falls back one repeat period.
  assign cnt_inc = (cnt == LAST) ? RELOAD : cnt + 1'b1;
  assign long_ev = held & (cnt_inc == LAST);
  assign ev      = rise | long_ev;
  assign drop    = ev & pend & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_btn <= 1'b0;
      cnt      <= '0;
      pend     <= 1'b0;
      kind     <= 1'b0;
    end else begin
      prev_btn <= btn;
      cnt      <= held ? cnt_inc : '0;
      // A grant clearing the slot in the same cycle frees it for the new event.
      if (ev && (!pend || clr)) begin
        pend <= 1'b1;
        kind <= long_ev;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

module btn_cmd_sched #(
  parameter int              N_BTN      = 4,
  parameter int              IDW        = 2,
  parameter int              CW         = 24,
  parameter logic [CW-1:0]   LONG_CYC   = 24'd5000000,
  parameter logic [CW-1:0]   REPEAT_CYC = 24'd1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_db,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDW-1:0]   cmd_id,
  output logic             cmd_long,
  output logic [N_BTN-1:0] pend,
  output logic [7:0]       drop_cnt
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] kind, drop, clr;
  logic [IDW-1:0]   rr_ptr, sel_idx;
  logic             sel_found, load, hs;
  logic [3:0]       n_drop;
  logic [8:0]       drop_sum;

  assign hs = cmd_valid & cmd_ready;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    assign clr[i] = hs & (cmd_id == IDW'(i));
    btn_lane #(.CW(CW), .LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_db[i]),
      .clr  (clr[i]),
      .pend (pend[i]),
      .kind (kind[i]),
      .drop (drop[i])
    );
  end

  // Round-robin search starts just after the last granted index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % N_BTN;
      if (!sel_found && pend[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:  if (sel_found) begin
               load      = 1'b1;
               state_nxt = OFFER;
             end
      OFFER: if (cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_BTN; i++) n_drop = n_drop + {3'b000, drop[i]};
    drop_sum = {1'b0, drop_cnt} + {5'b00000, n_drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      cmd_long  <= 1'b0;
      rr_ptr    <= IDW'(N_BTN - 1);
      drop_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_id    <= sel_idx;
        cmd_long  <= kind[sel_idx];
        rr_ptr    <= sel_idx;
      end else if (hs) begin
        cmd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_btn_cmd_sched.sv
// Directed bench for btn_cmd_sched: vector table for press/round-robin, hand
// sequences for hold/repeat, drops, grant-cycle re-press and reset mid-offer.

module tb_btn_cmd_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       rdy = 1'b0;
  logic       cmd_valid, cmd_long;
  logic [1:0] cmd_id;
  logic [3:0] pend;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  btn_cmd_sched #(.N_BTN(4), .IDW(2), .CW(24), .LONG_CYC(24'd8), .REPEAT_CYC(24'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_db    (btn),
    .cmd_valid (cmd_valid),
    .cmd_ready (rdy),
    .cmd_id    (cmd_id),
    .cmd_long  (cmd_long),
    .pend      (pend),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rb;
    logic [3:0] btn;
    logic       rdy;
    logic       vld;
    logic [1:0] id;
    logic       lng;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rb, logic [3:0] b, logic r, logic v, logic [1:0] id,
                              logic l, logic [3:0] p);
    vec_t t;
    t.rb = rb; t.btn = b; t.rdy = r; t.vld = v; t.id = id; t.lng = l; t.pend = p;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0; rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  int exp_edge[4];
  int exp_lng[4];
  int n;

  initial begin
    // Press of btn 2 (3 cycles), then simultaneous 0/3 presses twice.
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 4'b0100, 1, 1, 2, 0, 4'b0100));
    tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b1001, 1, 0, 0, 0, 4'b1001));
    tbl.push_back(mk(0, 4'b1001, 1, 1, 0, 0, 4'b1001));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 4'b1001, 1, 1, 3, 0, 4'b1000));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 4'b1001));
    tbl.push_back(mk(0, 4'b1001, 1, 1, 0, 0, 4'b1001));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 4'b1001, 1, 1, 3, 0, 4'b1000));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));

    // Reset state, checked before any clock edge.
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_id",    cmd_id,    0);
    chk("rst_long",  cmd_long,  0);
    chk("rst_pend",  pend,      0);
    chk("rst_drop",  drop_cnt,  0);

    foreach (tbl[k]) begin
      if (tbl[k].rb) begin
        if (k != 0) chk("t1_drop", drop_cnt, 0);
        do_reset();
      end
      btn = tbl[k].btn;
      rdy = tbl[k].rdy;
      step();
      chk($sformatf("vec%0d_valid", k), cmd_valid, tbl[k].vld);
      chk($sformatf("vec%0d_pend", k),  pend,      tbl[k].pend);
      if (tbl[k].vld) begin
        chk($sformatf("vec%0d_id", k),   cmd_id,   tbl[k].id);
        chk($sformatf("vec%0d_long", k), cmd_long, tbl[k].lng);
      end
    end

    // Hold btn 1: short, first long, then repeats every 4 cycles.
    exp_edge[0] = 1;  exp_lng[0] = 0;
    exp_edge[1] = 8;  exp_lng[1] = 1;
    exp_edge[2] = 12; exp_lng[2] = 1;
    exp_edge[3] = 16; exp_lng[3] = 1;
    do_reset();
    rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 26; c++) begin
      btn = (c < 19) ? 4'b0010 : 4'b0000;
      step();
      if (cmd_valid) begin
        if (n < 4) begin
          chk($sformatf("hold%0d_cycle", n), c, exp_edge[n]);
          chk($sformatf("hold%0d_long", n), cmd_long, exp_lng[n]);
          chk($sformatf("hold%0d_id", n), cmd_id, 1);
        end
        n++;
      end
    end
    chk("hold_count", n, 4);
    chk("hold_drop", drop_cnt, 0);

    // Second press while stalled is dropped; then saturate the drop counter.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      btn = (c < 2 || c == 4 || c == 5) ? 4'b0010 : 4'b0000;
      step();
    end
    chk("stall_valid", cmd_valid, 1);
    chk("stall_id",    cmd_id,    1);
    chk("stall_pend",  pend,      4'b0010);
    chk("stall_drop",  drop_cnt,  1);
    for (int c = 0; c < 300; c++) begin
      btn = 4'b0010; step();
      btn = 4'b0000; step();
    end
    chk("sat_drop",  drop_cnt,  255);
    chk("sat_valid", cmd_valid, 1);
    chk("sat_id",    cmd_id,    1);

    // Re-press landing on the grant cycle is latched, not dropped.
    do_reset();
    btn = 4'b0100; step(); step();
    chk("regrant_offer_valid", cmd_valid, 1);
    chk("regrant_offer_id",    cmd_id,    2);
    btn = 4'b0000; step(); step();
    btn = 4'b0100; rdy = 1'b1; step();
    chk("regrant_hs_valid", cmd_valid, 0);
    chk("regrant_hs_pend",  pend,      4'b0100);
    btn = 4'b0000; step();
    chk("regrant_valid2", cmd_valid, 1);
    chk("regrant_id2",    cmd_id,    2);
    chk("regrant_long2",  cmd_long,  0);
    step();
    chk("regrant_valid3", cmd_valid, 0);
    chk("regrant_pend3",  pend,      0);
    chk("regrant_drop",   drop_cnt,  0);

    // Reset mid-offer clears everything asynchronously.
    do_reset();
    btn = 4'b0100; step(); step();
    chk("abort_pre_valid", cmd_valid, 1);
    btn = 4'b0000; step();
    btn = 4'b0100; step();
    btn = 4'b0000; step();
    chk("abort_pre_drop", drop_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", cmd_valid, 0);
    chk("abort_id",    cmd_id,    0);
    chk("abort_long",  cmd_long,  0);
    chk("abort_pend",  pend,      0);
    chk("abort_drop",  drop_cnt,  0);
    step(); step();
    rst = 1'b0; rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post_abort%0d_valid", c), cmd_valid, 0);
    end
    btn = 4'b1000; step(); step();
    chk("post_abort_new_valid", cmd_valid, 1);
    chk("post_abort_new_id",    cmd_id,    3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
